// File: rtl/serial_out_scheduler.sv
// serial_out_scheduler
// Sequences decoded UART commands into CH_NUM serial output channels.
// A frequency command (0x0A) stages the bit periods and the slow/fast
// pattern. A data command (0x0B) becomes a start (load) or stop request
// for one channel. The block tracks which channels are running and drops
// illegal commands.
// Optional build macro: DROP_COUNT_EN enables the 8-bit saturating
// drop counter on drop_cnt_o. Without it, drop_cnt_o is tied to 0.
module serial_out_scheduler #(
  parameter int DATA_BIT    = 32,
  parameter int CH_NUM      = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dec_done_tick_i,
  input  logic [7:0]          dec_cmd_i,
  input  logic [DATA_BIT-1:0] dec_output_pattern_i,
  input  logic [DATA_BIT-1:0] dec_freq_pattern_i,
  input  logic [3:0]          dec_sel_out_i,
  input  logic                dec_start_i,
  input  logic                dec_stop_i,
  input  logic                dec_mode_i,
  input  logic [7:0]          dec_slow_period_i,
  input  logic [7:0]          dec_fast_period_i,
  input  logic [CH_NUM-1:0]   ch_ack_i,
  input  logic [CH_NUM-1:0]   ch_done_i,
  output logic [CH_NUM-1:0]   ch_load_o,
  output logic [CH_NUM-1:0]   ch_stop_o,
  output logic [DATA_BIT-1:0] cfg_pattern_o,
  output logic [DATA_BIT-1:0] cfg_freq_o,
  output logic [7:0]          cfg_slow_o,
  output logic [7:0]          cfg_fast_o,
  output logic                cfg_mode_o,
  output logic [CH_NUM-1:0]   ch_busy_o,
  output logic                sched_busy_o,
  output logic                overflow_o,
  output logic                cmd_err_o,
  output logic [7:0]          drop_cnt_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECIDE = 2'd1;
  localparam logic [1:0] S_LOAD   = 2'd2;

  localparam logic [7:0] CMD_FREQ = 8'h0A;
  localparam logic [7:0] CMD_DATA = 8'h0B;

  // Last cycle of the ack wait window; the timer starts at 0 on entry.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [CH_NUM-1:0] CH_ONE = {{(CH_NUM-1){1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [7:0]          tmr_q;

  logic                freq_valid_q;
  logic [DATA_BIT-1:0] freq_q;
  logic [7:0]          slow_q;
  logic [7:0]          fast_q;

  logic [DATA_BIT-1:0] pat_q;
  logic [3:0]          sel_q;
  logic                start_q;
  logic                stop_q;
  logic                mode_q;

  logic [CH_NUM-1:0]   busy_q, busy_d;
  logic                ovf_q;
  logic                err_q;

  logic                sel_ok;
  logic [CH_NUM-1:0]   ch_hot;
  logic                ack_hit;
  logic                tick_ovf;
  logic                fsm_drop;
  logic                freq_load;
  logic                pend_load;
  logic                stop_fire;
  logic                ack_set;
  logic                load_act;

  // Channel decode of the pending command; out-of-range selects hit nothing.
  always_comb begin
    sel_ok   = ({1'b0, sel_q} < 5'(CH_NUM));
    ch_hot   = sel_ok ? (CH_ONE << sel_q) : '0;
    ack_hit  = |(ch_ack_i & ch_hot);
    tick_ovf = dec_done_tick_i && (state_q != S_IDLE);
    load_act = (state_q == S_LOAD);
    stop_fire = (state_q == S_DECIDE) && sel_ok && stop_q;
    ack_set   = load_act && ack_hit;
  end

  // Next-state logic and drop detection.
  always_comb begin
    state_d   = state_q;
    fsm_drop  = 1'b0;
    freq_load = 1'b0;
    pend_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dec_done_tick_i) begin
          if (dec_cmd_i == CMD_FREQ) begin
            if ((dec_slow_period_i != 8'd0) && (dec_fast_period_i != 8'd0))
              freq_load = 1'b1;
            else
              fsm_drop = 1'b1;
          end else if (dec_cmd_i == CMD_DATA) begin
            pend_load = 1'b1;
            state_d   = S_DECIDE;
          end
        end
      end
      S_DECIDE: begin
        state_d = S_IDLE;
        if (!sel_ok) begin
          fsm_drop = 1'b1;
        end else if (stop_q) begin
          // Stop pulse and busy clear are decoded from stop_fire.
          fsm_drop = 1'b0;
        end else if (start_q) begin
          if ((|(busy_q & ch_hot)) || !freq_valid_q)
            fsm_drop = 1'b1;
          else
            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ack_hit) begin
          state_d = S_IDLE;
        end else if (tmr_q == TMO_LAST) begin
          fsm_drop = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Busy flags: done and stop clear, ack sets, and set wins on a collision.
  always_comb begin
    busy_d = busy_q & ~ch_done_i;
    if (stop_fire) busy_d = busy_d & ~ch_hot;
    if (ack_set)   busy_d = busy_d | ch_hot;
  end

  // Control state, staged frequency config and sticky flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      tmr_q        <= 8'd0;
      freq_valid_q <= 1'b0;
      freq_q       <= '0;
      slow_q       <= 8'd0;
      fast_q       <= 8'd0;
      busy_q       <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= load_act ? (tmr_q + 8'd1) : 8'd0;
      busy_q  <= busy_d;
      if (freq_load) begin
        freq_valid_q <= 1'b1;
        freq_q       <= dec_freq_pattern_i;
        slow_q       <= dec_slow_period_i;
        fast_q       <= dec_fast_period_i;
      end
      if (tick_ovf)            ovf_q <= 1'b1;
      if (tick_ovf || fsm_drop) err_q <= 1'b1;
    end
  end

  // Pending data command; only observed after it has been captured.
  always_ff @(posedge clk_i) begin
    if (pend_load) begin
      pat_q   <= dec_output_pattern_i;
      sel_q   <= dec_sel_out_i;
      start_q <= dec_start_i;
      stop_q  <= dec_stop_i;
      mode_q  <= dec_mode_i;
    end
  end

`ifdef DROP_COUNT_EN
  logic [7:0] drop_cnt_q;
  logic [1:0] drop_inc;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign drop_inc = {1'b0, fsm_drop} + {1'b0, tick_ovf};

  // Saturating count of drops and overflows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= sat_add(drop_cnt_q, drop_inc);
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 8'd0;
`endif

  // Moore output decode; the config bus is driven only during a load.
  always_comb begin
    ch_load_o     = load_act ? ch_hot : '0;
    ch_stop_o     = stop_fire ? ch_hot : '0;
    cfg_pattern_o = load_act ? pat_q : '0;
    cfg_freq_o    = load_act ? freq_q : '0;
    cfg_slow_o    = load_act ? slow_q : 8'd0;
    cfg_fast_o    = load_act ? fast_q : 8'd0;
    cfg_mode_o    = load_act && mode_q;
    ch_busy_o     = busy_q;
    sched_busy_o  = (state_q != S_IDLE);
    overflow_o    = ovf_q;
    cmd_err_o     = err_q;
  end

endmodule

// File: tb/tb_serial_out_scheduler.sv
// Directed bench for serial_out_scheduler (CH_NUM=8, ACK_TIMEOUT=10).
module tb_serial_out_scheduler;

  localparam int DW = 32;
  localparam int CN = 8;
  localparam int AT = 10;
`ifdef DROP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [7:0]    cmd;
  logic [DW-1:0] opat, fpat;
  logic [3:0]    sel;
  logic          start, stop, mode;
  logic [7:0]    slow, fast;
  logic [CN-1:0] ack, done;
  logic [CN-1:0] ch_load, ch_stop, ch_busy;
  logic [DW-1:0] cfg_pattern, cfg_freq;
  logic [7:0]    cfg_slow, cfg_fast, drop_cnt;
  logic          cfg_mode, sched_busy, overflow, cmd_err;

  int n_chk = 0;
  int n_err = 0;
  int cnt;

  serial_out_scheduler #(.DATA_BIT(DW), .CH_NUM(CN), .ACK_TIMEOUT(AT)) dut (
    .clk_i(clk), .rst_i(rst), .dec_done_tick_i(tick), .dec_cmd_i(cmd),
    .dec_output_pattern_i(opat), .dec_freq_pattern_i(fpat),
    .dec_sel_out_i(sel), .dec_start_i(start), .dec_stop_i(stop),
    .dec_mode_i(mode), .dec_slow_period_i(slow), .dec_fast_period_i(fast),
    .ch_ack_i(ack), .ch_done_i(done), .ch_load_o(ch_load), .ch_stop_o(ch_stop),
    .cfg_pattern_o(cfg_pattern), .cfg_freq_o(cfg_freq), .cfg_slow_o(cfg_slow),
    .cfg_fast_o(cfg_fast), .cfg_mode_o(cfg_mode), .ch_busy_o(ch_busy),
    .sched_busy_o(sched_busy), .overflow_o(overflow), .cmd_err_o(cmd_err),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_drop(input int n);
    if (!CNT_EN) return 8'd0;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  // Called at a negedge; tick is high for one clock edge, returns one negedge later.
  task automatic send(input logic [7:0] c, input logic [3:0] s, input logic st,
                      input logic sp, input logic md, input logic [7:0] sl,
                      input logic [7:0] fa, input logic [DW-1:0] op,
                      input logic [DW-1:0] fp);
    cmd = c; sel = s; start = st; stop = sp; mode = md;
    slow = sl; fast = fa; opat = op; fpat = fp; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; cmd = 8'h00; opat = '0; fpat = '0; sel = 4'd0;
    start = 1'b0; stop = 1'b0; mode = 1'b0; slow = 8'd0; fast = 8'd0;
    ack = '0; done = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_load",  ch_load, 0);
    chk("rst_busy",  ch_busy, 0);
    chk("rst_sched", sched_busy, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_err",   cmd_err, 0);
    chk("rst_drop",  drop_cnt, 0);
    chk("rst_slow",  cfg_slow, 0);

    // Unknown command is ignored silently
    send(8'h55, 4'd3, 1'b1, 1'b0, 1'b0, 8'd8, 8'd2, 32'h1, 32'h1);
    chk("ign_sched", sched_busy, 0);
    chk("ign_err",   cmd_err, 0);

    // Start with no frequency staged, then an out-of-range channel
    send(8'h0B, 4'd2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'h1234, 32'h0);
    @(negedge clk);
    chk("nofreq_err",  cmd_err, 1);
    chk("nofreq_load", ch_load, 0);
    chk("nofreq_drop", drop_cnt, exp_drop(1));
    send(8'h0B, 4'd15, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'h1234, 32'h0);
    @(negedge clk);
    chk("sel_drop",  drop_cnt, exp_drop(2));
    chk("sel_sched", sched_busy, 0);
    chk("sel_load",  ch_load, 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_err", cmd_err, 0);

    // Freq config, then start on channel 3 acked after 2 load cycles
    send(8'h0A, 4'd0, 1'b0, 1'b0, 1'b0, 8'd8, 8'd2, 32'h0, 32'h0000FFFF);
    chk("freq_err", cmd_err, 0);
    send(8'h0B, 4'd3, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 32'hA5A50F0F, 32'h0);
    chk("n1_sched", sched_busy, 1);
    chk("n1_load",  ch_load, 0);
    @(negedge clk);
    chk("n2_load",  ch_load, 8'h08);
    chk("n2_slow",  cfg_slow, 8);
    chk("n2_fast",  cfg_fast, 2);
    chk("n2_freq",  cfg_freq, 32'h0000FFFF);
    chk("n2_pat",   cfg_pattern, 32'hA5A50F0F);
    chk("n2_mode",  cfg_mode, 1);
    ack = 8'h10;
    @(negedge clk);
    chk("n3_load", ch_load, 8'h08);
    ack = 8'h08;
    @(negedge clk);
    ack = '0;
    chk("ack_load",  ch_load, 0);
    chk("ack_busy",  ch_busy, 8'h08);
    chk("ack_sched", sched_busy, 0);
    chk("ack_slow",  cfg_slow, 0);

    // Start on a busy channel is dropped
    send(8'h0B, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'h1, 32'h0);
    chk("bz_stop", ch_stop, 0);
    @(negedge clk);
    chk("bz_load", ch_load, 0);
    chk("bz_err",  cmd_err, 1);
    chk("bz_drop", drop_cnt, exp_drop(1));
    chk("bz_busy", ch_busy, 8'h08);

    // Stop wins over start
    send(8'h0B, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 32'h1, 32'h0);
    chk("stp_pulse", ch_stop, 8'h08);
    @(negedge clk);
    chk("stp_end",  ch_stop, 0);
    chk("stp_busy", ch_busy, 0);
    chk("stp_load", ch_load, 0);

    // Stop to an idle channel is legal
    send(8'h0B, 4'd5, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 32'h1, 32'h0);
    chk("stpi_pulse", ch_stop, 8'h20);
    @(negedge clk);
    chk("stpi_drop", drop_cnt, exp_drop(1));

    // Timeout with an overflowing tick during the load
    send(8'h0B, 4'd1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'h77, 32'h0);
    @(negedge clk);
    chk("to_load", ch_load, 8'h02);
    cnt = 1;
    send(8'h0A, 4'd0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd3, 32'h0, 32'hFFFF0000);
    while (ch_load != 0 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_cycles", cnt, AT);
    chk("to_ovf",    overflow, 1);
    chk("to_sched",  sched_busy, 0);
    chk("to_busy",   ch_busy, 0);
    chk("to_drop",   drop_cnt, exp_drop(3));

    // Overflowed config left the staged periods alone; then done clears busy
    send(8'h0B, 4'd1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'h77, 32'h0);
    @(negedge clk);
    chk("re_load", ch_load, 8'h02);
    chk("re_slow", cfg_slow, 8);
    chk("re_freq", cfg_freq, 32'h0000FFFF);
    ack = 8'h02;
    @(negedge clk);
    ack = '0;
    chk("re_busy", ch_busy, 8'h02);
    done = 8'h02;
    @(negedge clk);
    done = '0;
    chk("done_busy", ch_busy, 0);

    // Async reset in the middle of a load
    send(8'h0B, 4'd6, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'h1, 32'h0);
    @(negedge clk);
    ack = 8'h40;
    @(negedge clk);
    ack = '0;
    chk("b6_busy", ch_busy, 8'h40);
    send(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'h3, 32'h0);
    @(negedge clk);
    chk("ar_load0", ch_load, 8'h10);
    #2 rst = 1'b1;
    #1;
    chk("ar_load",  ch_load, 0);
    chk("ar_busy",  ch_busy, 0);
    chk("ar_sched", sched_busy, 0);
    chk("ar_ovf",   overflow, 0);
    chk("ar_err",   cmd_err, 0);
    chk("ar_slow",  cfg_slow, 0);
    chk("ar_drop",  drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 300 invalid frequency commands saturate the drop counter
    for (int i = 0; i < 300; i++)
      send(8'h0A, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd5, 32'h0, 32'h0);
    @(negedge clk);
    chk("sat_drop",  drop_cnt, exp_drop(300));
    chk("sat_err",   cmd_err, 1);
    chk("sat_sched", sched_busy, 0);
    chk("sat_ovf",   overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
